// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO read scheduler.
package fifo_rd_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefMaxBurst  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StArb,
        StBurst
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past ptr and wraps.
module rr_arbiter
    import fifo_rd_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    localparam int unsigned PtrW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PtrW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PtrW'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_scheduler.sv
// Read-side scheduler: grants the FIFO to one requester at a time for bursts of up to
// MAX_BURST words and steers the registered read word to that requester.
module fifo_rd_scheduler
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned MAX_BURST  = DefMaxBurst
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  r_en,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic                  busy
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    rd_state_e             state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [PtrW-1:0]       owner_q;
    logic [PtrW-1:0]       ptr_q;
    logic [CntW-1:0]       cnt_q;
    logic [NUM_REQ-1:0]    rd_valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  rst_done_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PtrW-1:0]       win_idx;
    logic                  owner_req;
    logic                  burst_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx = PtrW'(i);
            end
        end
    end

    assign owner_req = req[owner_q];
    assign r_en      = (state_q == StBurst) && owner_req && !f_empty && (cnt_q != '0);
    // Emptiness never ends a burst; only the last pop or the owner letting go does.
    assign burst_end = (state_q == StBurst) &&
                       (!owner_req || (r_en && (cnt_q == CntW'(1))));

    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= PtrW'(NUM_REQ - 1);
            cnt_q      <= '0;
            rd_valid_q <= '0;
            data_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            rd_valid_q <= r_en ? gnt_q : '0;
            if (r_en) begin
                data_q <= mem_data_out;
            end
            unique case (state_q)
                StIdle: begin
                    // Hold off one edge after reset release before arbitrating.
                    if (rst_done_q && |req) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (|arb_gnt) begin
                        gnt_q   <= arb_gnt;
                        owner_q <= win_idx;
                        cnt_q   <= CntW'(MAX_BURST);
                        state_q <= StBurst;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBurst: begin
                    if (r_en) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                    if (burst_end) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        ptr_q   <= owner_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rd_valid = rd_valid_q;
    assign data_out = data_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_rd_scheduler.sv
// Randomised bench for fifo_rd_scheduler against a transaction-level model of bursts.
module tb_fifo_rd_scheduler;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int MB = 8;

    logic          r_clk = 1'b0;
    logic          rrst = 1'b0;
    logic [NR-1:0] req = '0;
    logic          f_empty = 1'b1;
    logic [DW-1:0] mem_data_out = '0;
    logic          r_en;
    logic [NR-1:0] gnt;
    logic [DW-1:0] data_out;
    logic [NR-1:0] rd_valid;
    logic          busy;

    fifo_rd_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .r_clk        (r_clk),
        .rrst         (rrst),
        .req          (req),
        .f_empty      (f_empty),
        .mem_data_out (mem_data_out),
        .r_en         (r_en),
        .gnt          (gnt),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .busy         (busy)
    );

    always #5 r_clk = ~r_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 arbitrating, 2 bursting; bursts counted up in words popped.
    int            m_phase;
    int            m_owner;
    int            m_popped;
    int            m_last;
    int            m_dest;
    bit            m_armed;
    logic [DW-1:0] m_data;

    task automatic model_reset();
        m_phase  = 0;
        m_owner  = 0;
        m_popped = 0;
        m_last   = NR - 1;
        m_dest   = -1;
        m_armed  = 1'b0;
        m_data   = '0;
    endtask

    function automatic bit model_pop();
        return (m_phase == 2) && req[m_owner] && !f_empty && (m_popped < MB);
    endfunction

    task automatic model_edge();
        bit pop;
        int cand;
        if (!rrst) begin
            model_reset();
            return;
        end
        pop    = model_pop();
        m_dest = pop ? m_owner : -1;
        if (pop) m_data = mem_data_out;
        if (m_phase == 0) begin
            if (m_armed && (req != 0)) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 0;
            for (int k = 1; k <= NR; k++) begin
                cand = (m_last + k) % NR;
                if (req[cand]) begin
                    m_owner  = cand;
                    m_popped = 0;
                    m_phase  = 2;
                    break;
                end
            end
        end else begin
            if (pop) m_popped++;
            if (!req[m_owner] || (pop && m_popped == MB)) begin
                m_phase = 0;
                m_last  = m_owner;
            end
        end
        m_armed = 1'b1;
    endtask

    task automatic check_outputs();
        logic [63:0] exp_gnt;
        logic [63:0] exp_rdv;
        exp_gnt = (m_phase == 2) ? (64'd1 << m_owner) : 64'd0;
        exp_rdv = (m_dest >= 0) ? (64'd1 << m_dest) : 64'd0;
        check("r_en", 64'(r_en), 64'(model_pop()));
        check("gnt", 64'(gnt), exp_gnt);
        check("busy", 64'(busy), 64'(m_phase != 0));
        check("rd_valid", 64'(rd_valid), exp_rdv);
        check("data_out", 64'(data_out), 64'(m_data));
    endtask

    initial begin
        int level;
        int mode;
        bit popped_at_edge;
        model_reset();
        level = 0;
        rrst = 1'b0;
        req = '1;
        f_empty = 1'b0;
        #1 check_outputs();
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(posedge r_clk);
            popped_at_edge = model_pop() && rrst;
            model_edge();
            mode = (cyc < 50) ? 2 : (cyc < 140) ? 1 : 0;
            if (mode == 2 && popped_at_edge && level > 0) level--;
            #1;
            if (cyc == 3) rrst = 1'b1;
            if (cyc == 4) level = 10;
            mem_data_out = $urandom;
            if (mode == 2) begin
                req     = 4'b0001;
                f_empty = (level == 0);
            end else if (mode == 1) begin
                req     = 4'b1111;
                f_empty = 1'b0;
            end else begin
                for (int b = 0; b < NR; b++) begin
                    if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
                end
                f_empty = ($urandom_range(0, 3) == 0);
            end
            #1 check_outputs();
            if (mode == 0 && $urandom_range(0, 99) == 0) begin
                rrst = 1'b0;
                model_reset();
                #1 check_outputs();
                #1 rrst = 1'b1;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo_rd_scheduler.md
FIFO_RD_SCHEDULER -- requirements
Module: fifo_rd_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the FIFO word width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of read requesters (legal range 2..8).
REQ-003 The block SHALL have parameter MAX_BURST, default 8, giving the maximum words per grant (legal range 1..16).
REQ-004 The block SHALL have port r_clk, input, 1 bit: read-domain clock; all logic is rising-edge triggered.
REQ-005 The block SHALL have port rrst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester read request, level, held while the requester wants data.
REQ-007 The block SHALL have port f_empty, input, 1 bit: FIFO empty flag, already synchronised to r_clk.
REQ-008 The block SHALL have port mem_data_out, input, DATA_WIDTH bits: FIFO read data, valid in the cycle after r_en.
REQ-009 The block SHALL have port r_en, output, 1 bit: FIFO read strobe; one word is popped per cycle it is high.
REQ-010 The block SHALL have port gnt, output, NUM_REQ bits: one-hot current owner, all zero when idle.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read word.
REQ-012 The block SHALL have port rd_valid, output, NUM_REQ bits: one-hot qualifier for data_out, naming the destination requester.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ARB and BURST.
- IDLE -> ARB when |req is high.
- ARB -> BURST after one cycle, latching the winner into gnt.
- BURST -> IDLE at burst end.
REQ-015 Arbitration SHALL be round-robin: the search starts at the index after the last grantee, and index 0 has priority after reset.
REQ-016 In BURST, r_en SHALL equal (req[owner] && !f_empty && words_left != 0), combinationally from registered state.
REQ-017 The word counter SHALL load MAX_BURST on entry to BURST and decrement once per cycle r_en is high; its width is clog2(MAX_BURST+1).
REQ-018 Burst end SHALL occur at the first cycle where either (the counter reaches 0 after a pop) or (req[owner] is low); gnt clears on the next edge.
REQ-019 While f_empty is high in BURST, the block SHALL stall: r_en stays low, the counter holds, and gnt holds. The burst does not end on empty.
REQ-020 If req[owner] falls in the same cycle f_empty rises, the burst SHALL end, and no pop occurs that cycle.
REQ-021 Exactly one cycle after each cycle with r_en high, data_out SHALL equal that cycle's mem_data_out and rd_valid SHALL equal the owner's one-hot value.
- rd_valid is zero otherwise.
- data_out holds its last value when rd_valid is zero.
REQ-022 The last word of a burst SHALL still be delivered with rd_valid, even though gnt has already cleared.
REQ-023 The round-robin pointer SHALL update to the owner index only at burst end.
REQ-024 Requests arriving during BURST SHALL wait, with no preemption.
REQ-025 The minimum gap between consecutive bursts SHALL be 2 cycles (IDLE, ARB), and r_en SHALL never be high outside BURST.

Reset
REQ-026 On rrst low, the block SHALL reset asynchronously as follows:
- state = IDLE, r_en = 0, gnt = 0, rd_valid = 0, data_out = 0, busy = 0.
- counter = 0, RR pointer = NUM_REQ-1 (so index 0 wins first).
REQ-027 Reset asserted mid-burst SHALL abort the burst immediately. A word popped in the reset cycle SHALL NOT produce rd_valid.
REQ-028 After rrst deasserts, the first ARB SHALL occur no earlier than the second rising edge.

Structure
REQ-029 The state enum (IDLE/ARB/BURST) and the default parameter constants SHALL live in package fifo_rd_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req, pointer; output: one-hot grant).
- rr_arbiter is purely combinational, parameterised by NUM_REQ.
- The FSM, counter and data register stay in fifo_rd_scheduler.

Verification
REQ-031 Single requester: req=4'b0001, FIFO holds 10 words, f_empty low. Required response:
- Exactly 8 r_en pulses.
- 8 rd_valid=4'b0001 beats in order.
- Then IDLE, then a second burst of 2 words.
REQ-032 Round-robin fairness: req=4'b1111 constantly, FIFO never empty. Required response:
- Grants occur in the order 0,1,2,3,0.
- Each grant lasts 8 pops.
- The gap between bursts is 2 cycles.
REQ-033 Empty stall: f_empty is high for 5 cycles after the 3rd pop. Required response:
- r_en stays low for those 5 cycles.
- The counter holds at 5.
- The burst resumes and completes 8 words total.
REQ-034 Early release: req[2] drops after 3 pops. Required response:
- 3 rd_valid=4'b0100 beats.
- gnt clears the next cycle.
- The pointer advances so that requester 3 wins next.
REQ-035 Simultaneous events: req[owner] falls in the same cycle f_empty rises. Required response: no pop that cycle, and IDLE on the next edge.
REQ-036 Reset mid-burst: rrst pulses low during the 4th pop. Required response:
- All outputs are 0 within the same cycle.
- No rd_valid follows.
- The next grant goes to requester 0.
